// File: rtl/dct_block_ctrl.sv
// dct_block_ctrl
//   Sequencing controller for an 8x8 two-pass (row, then column) DCT built on
//   a systolic array. The controller has no sample datapath. The row pass
//   streams upstream pixels into the array. Row results are stored row-major
//   in a transpose buffer. The column pass reads that buffer in transposed
//   order back into the array. Column results are forwarded downstream.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   s_valid / s_ready       upstream pixel beat handshake
//   res_valid               result beat from the systolic array
//   arr_valid, arr_src      array input strobe; mux select (0 pixel, 1 tbuf)
//   arr_first, coef_k       group-start flag and coefficient index 0..7
//   pass                    0 row pass, 1 column pass
//   tbuf_we, tbuf_waddr     transpose buffer write strobe / address
//   tbuf_re, tbuf_raddr     transpose buffer read strobe / address (1-cycle latency)
//   out_valid, block_done   final coefficient beat; end-of-block pulse
//   busy, err               controller active; sticky protocol error
module dct_block_ctrl #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned BLK        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       res_valid,
    output logic       arr_valid,
    output logic       arr_src,
    output logic       arr_first,
    output logic [2:0] coef_k,
    output logic       pass,
    output logic       tbuf_we,
    output logic [5:0] tbuf_waddr,
    output logic       tbuf_re,
    output logic [5:0] tbuf_raddr,
    output logic       out_valid,
    output logic       block_done,
    output logic       busy,
    output logic       err
);

    localparam logic [5:0] LAST = 6'(BLK * BLK - 1);

    // Counter and address widths are fixed for an 8x8 block. DATA_WIDTH only
    // describes the surrounding datapath. This empty guard keeps both
    // parameters part of elaboration.
    if (DATA_WIDTH == 0 || BLK != 8) begin : gGeometryUnsupported
    end

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        ROW_DRAIN,
        COL,
        COL_DRAIN
    } state_t;

    state_t     state, stateNext;
    logic [5:0] inCnt, inCntNext;
    logic [5:0] resCnt, resCntNext;
    logic [5:0] rdCnt, rdCntNext;
    logic       dlyValid;
    logic [2:0] dlyK;
    logic       errReg;
    logic       accept;
    logic       resBad;

    always_comb begin
        stateNext  = state;
        inCntNext  = inCnt;
        resCntNext = resCnt;
        rdCntNext  = rdCnt;
        s_ready    = 1'b0;
        accept     = 1'b0;
        resBad     = 1'b0;
        tbuf_we    = 1'b0;
        tbuf_re    = 1'b0;
        out_valid  = 1'b0;
        block_done = 1'b0;

        case (state)
            IDLE: begin
                // s_ready is gated by rst_n so it reads 0 while reset is held.
                s_ready = rst_n;
                accept  = s_valid & rst_n;
                resBad  = res_valid;
                if (accept) begin
                    inCntNext = inCnt + 6'd1;
                    stateNext = ROW;
                end
            end
            ROW: begin
                s_ready = rst_n;
                accept  = s_valid & rst_n;
                resBad  = res_valid;
                if (accept) begin
                    if (inCnt == LAST) begin
                        inCntNext = '0;
                        stateNext = ROW_DRAIN;
                    end else begin
                        inCntNext = inCnt + 6'd1;
                    end
                end
            end
            ROW_DRAIN: begin
                if (res_valid) begin
                    tbuf_we = 1'b1;
                    if (resCnt == LAST) begin
                        resCntNext = '0;
                        stateNext  = COL;
                    end else begin
                        resCntNext = resCnt + 6'd1;
                    end
                end
            end
            COL: begin
                tbuf_re = 1'b1;
                resBad  = res_valid;
                if (rdCnt == LAST) begin
                    rdCntNext = '0;
                    stateNext = COL_DRAIN;
                end else begin
                    rdCntNext = rdCnt + 6'd1;
                end
            end
            COL_DRAIN: begin
                out_valid = res_valid;
                if (res_valid) begin
                    if (resCnt == LAST) begin
                        resCntNext = '0;
                        block_done = 1'b1;
                        stateNext  = IDLE;
                    end else begin
                        resCntNext = resCnt + 6'd1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        // A column-pass array beat comes from the delay stage. It lines up with
        // the buffer read data and can spill one cycle into COL_DRAIN.
        // Row-pass beats are combinational on the handshake.
        arr_valid  = accept | dlyValid;
        arr_src    = dlyValid;
        coef_k     = dlyValid ? dlyK : inCnt[2:0];
        arr_first  = arr_valid & (coef_k == 3'd0);
        tbuf_waddr = resCnt;
        tbuf_raddr = {rdCnt[2:0], rdCnt[5:3]};
        pass       = (state == COL) || (state == COL_DRAIN);
        busy       = (state != IDLE);
        err        = errReg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            inCnt    <= '0;
            resCnt   <= '0;
            rdCnt    <= '0;
            dlyValid <= 1'b0;
            dlyK     <= '0;
            errReg   <= 1'b0;
        end else begin
            state    <= stateNext;
            inCnt    <= inCntNext;
            resCnt   <= resCntNext;
            rdCnt    <= rdCntNext;
            dlyValid <= tbuf_re;
            dlyK     <= rdCnt[2:0];
            if (resBad) begin
                errReg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_block_ctrl.sv
module tb_dct_block_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic       res_valid;
    logic       arr_valid;
    logic       arr_src;
    logic       arr_first;
    logic [2:0] coef_k;
    logic       pass;
    logic       tbuf_we;
    logic [5:0] tbuf_waddr;
    logic       tbuf_re;
    logic [5:0] tbuf_raddr;
    logic       out_valid;
    logic       block_done;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    dct_block_ctrl #(.DATA_WIDTH(10), .BLK(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .res_valid(res_valid), .arr_valid(arr_valid), .arr_src(arr_src),
        .arr_first(arr_first), .coef_k(coef_k), .pass(pass),
        .tbuf_we(tbuf_we), .tbuf_waddr(tbuf_waddr), .tbuf_re(tbuf_re),
        .tbuf_raddr(tbuf_raddr), .out_valid(out_valid),
        .block_done(block_done), .busy(busy), .err(err)
    );

    int nChecks = 0;
    int nFails  = 0;
    int cycNo   = 0;
    int bdSeen  = 0;
    int rowPulses = 0;

    // Reference model state: progress of the current block as beat counts.
    int mAcc, mRr, mRd, mCr, mPrevIdx, mBlocks;
    bit mErr, mPrevRd;

    typedef struct {
        logic       sv;
        logic       rv;
        logic [7:0] exp;   // {s_ready, arr_valid, arr_first, coef_k, busy, err}
    } vec_t;

    task automatic check(input string name, input logic [25:0] act,
                         input logic [25:0] exp, input logic [25:0] mask);
        nChecks++;
        if ((act & mask) !== (exp & mask)) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (mask %h)", name, act & mask, exp & mask, mask);
        end
    endtask

    function automatic logic [25:0] dutOut();
        return {s_ready, arr_valid, arr_src, arr_first, coef_k, pass, tbuf_we,
                tbuf_waddr, tbuf_re, tbuf_raddr, out_valid, block_done, busy, err};
    endfunction

    function automatic bit inDrain();
        return (mAcc == 64 && mRr < 64) || (mRd == 64);
    endfunction

    task automatic modelClear();
        mAcc = 0; mRr = 0; mRd = 0; mCr = 0;
        mPrevRd = 0; mPrevIdx = 0; mErr = 0;
    endtask

    task automatic doReset();
        s_valid = 1'b0;
        res_valid = 1'b0;
        rst_n = 1'b0;
        modelClear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model by the beats that this cycle completes.
    task automatic step(input logic sv, input logic rv);
        logic idle, row, rdr, col, cdr, acc, we, re, ov, bd, av;
        int k;
        logic [25:0] exp, mask;
        @(negedge clk);
        s_valid = sv;
        res_valid = rv;
        #1;
        idle = (mAcc == 0);
        row  = (mAcc > 0 && mAcc < 64);
        rdr  = (mAcc == 64 && mRr < 64);
        col  = (mRr == 64 && mRd < 64);
        cdr  = (mRd == 64);
        acc  = sv && (idle || row);
        we   = rdr && rv;
        re   = col;
        ov   = cdr && rv;
        bd   = ov && (mCr == 63);
        av   = acc || mPrevRd;
        k    = mPrevRd ? (mPrevIdx % 8) : (mAcc % 8);
        exp  = {1'(idle || row), av, 1'(mPrevRd), 1'(av && k == 0), 3'(k),
                1'(col || cdr), we, 6'(mRr), re, 6'((mRd % 8) * 8 + mRd / 8),
                ov, bd, 1'(!idle), 1'(mErr)};
        mask = '1;
        if (!av) mask[21:19] = 3'b000;
        if (!we) mask[16:11] = 6'b0;
        if (!re) mask[9:4]   = 6'b0;
        check($sformatf("cycle%0d", cycNo), dutOut(), exp, mask);
        if (block_done) bdSeen++;
        if (arr_valid && !arr_src) rowPulses++;
        if (rv && (idle || row || col)) mErr = 1;
        if (acc) mAcc++;
        if (we) mRr++;
        mPrevRd  = re;
        mPrevIdx = mRd;
        if (re) mRd++;
        if (ov) mCr++;
        if (mCr == 64) begin
            mAcc = 0; mRr = 0; mRd = 0; mCr = 0;
            mBlocks++;
        end
        cycNo++;
    endtask

    // Full block: pixels always offered except nStall idle cycles at beat 10,
    // results returned on every drain cycle. Bounded by a cycle budget.
    task automatic runBlock(input string name, input int nStall);
        int start = mBlocks;
        int stalls = 0;
        logic sv;
        for (int n = 0; n < 600 && mBlocks == start; n++) begin
            sv = 1'b1;
            if (mAcc == 10 && stalls < nStall) begin
                sv = 1'b0;
                stalls++;
            end
            step(sv, 1'(inDrain()));
        end
        nChecks++;
        if (mBlocks == start) begin
            nFails++;
            $display("FAIL %s_timeout: got 0 blocks expected 1", name);
        end
    endtask

    task automatic runRandom(input int cycles, input int errPct);
        logic sv, rv;
        for (int n = 0; n < cycles; n++) begin
            sv = ($urandom_range(0, 99) < 75);
            if (inDrain()) rv = ($urandom_range(0, 99) < 60);
            else           rv = ($urandom_range(0, 99) < errPct);
            step(sv, rv);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t vecs[6];
        mBlocks = 0;
        modelClear();

        // Reset state: every output low, including s_ready.
        s_valid = 1'b1;
        res_valid = 1'b1;
        rst_n = 1'b0;
        #12;
        check("reset_outputs", dutOut(), 26'd0, '1);
        doReset();

        // Directed start-of-block vectors.
        vecs[0] = '{sv: 1'b0, rv: 1'b0, exp: 8'b10000000};
        vecs[1] = '{sv: 1'b1, rv: 1'b0, exp: 8'b11100000};
        vecs[2] = '{sv: 1'b1, rv: 1'b0, exp: 8'b11000110};
        vecs[3] = '{sv: 1'b0, rv: 1'b0, exp: 8'b10001010};
        vecs[4] = '{sv: 1'b1, rv: 1'b1, exp: 8'b11001010};
        vecs[5] = '{sv: 1'b0, rv: 1'b0, exp: 8'b10001111};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_valid = vecs[i].sv;
            res_valid = vecs[i].rv;
            #1;
            check($sformatf("vec%0d", i),
                  {18'd0, s_ready, arr_valid, arr_first, coef_k, busy, err},
                  {18'd0, vecs[i].exp}, '1);
        end
        doReset();

        // Clean block, no stalls.
        bdSeen = 0; rowPulses = 0;
        runBlock("block_plain", 0);
        checkInt("plain_row_pulses", rowPulses, 64);
        checkInt("plain_block_done", bdSeen, 1);

        // Three stall cycles at beat 10.
        bdSeen = 0; rowPulses = 0;
        runBlock("block_stall", 3);
        checkInt("stall_row_pulses", rowPulses, 64);
        checkInt("stall_block_done", bdSeen, 1);

        // Stray result in IDLE: err sticks through a whole block.
        step(1'b0, 1'b1);
        runBlock("block_err", 0);
        checkInt("err_sticky", int'(err), 1);
        doReset();
        checkInt("err_cleared", int'(err), 0);

        // Randomized traffic, first clean, then with stray results.
        runRandom(3000, 0);
        doReset();
        runRandom(2000, 3);
        doReset();

        // Reset in the middle of the column pass, at read 20.
        for (int n = 0; n < 400 && !(mRr == 64 && mRd == 20); n++)
            step(1'b1, 1'(inDrain()));
        checkInt("reached_col_rd20", mRd, 20);
        @(negedge clk);
        s_valid = 1'b0;
        res_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midblock_reset_outputs", dutOut(), 26'd0, '1);
        modelClear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bdSeen = 0;
        runBlock("block_after_reset", 0);
        checkInt("after_reset_block_done", bdSeen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
